// File: rtl/uart_pkg.sv
// Shared UART types and constants for the receive and transmit controllers.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_e;

    localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Byte-side handshake of the UART receiver; parity_err exists only with UART_RX_PARITY_EN.
interface uart_rx_ctrl_if #(
    parameter int DATA_BITS = 8
);

    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 frame_err;
    logic                 overrun;
`ifdef UART_RX_PARITY_EN
    logic                 parity_err;
`endif

    modport master (
        input  rx_ready,
        output rx_data, rx_valid, frame_err, overrun
`ifdef UART_RX_PARITY_EN
        , parity_err
`endif
    );

    modport slave (
        output rx_ready,
        input  rx_data, rx_valid, frame_err, overrun
`ifdef UART_RX_PARITY_EN
        , parity_err
`endif
    );

endinterface

// File: rtl/uart_rx_sync.sv
// Multi-flop synchronizer for the asynchronous serial line; resets to the idle level.
module uart_rx_sync
    import uart_pkg::*;
#(
    parameter int SYNC_STAGES = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic serial,
    output logic line
);

    logic [SYNC_STAGES-1:0] sync_p0;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= {SYNC_STAGES{UART_IDLE_LEVEL}};
        end else begin
            sync_p0 <= {sync_p0[SYNC_STAGES-2:0], serial};
        end
    end

    assign line = sync_p0[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: oversampling FSM, baud/bit counters and a valid/ready holding register.
// Optional parity checking is built when UART_RX_PARITY_EN is defined.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int SYNC_STAGES  = 3
`ifdef UART_RX_PARITY_EN
    ,
    parameter int PARITY_ODD   = 0
`endif
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           rx_serial,
    uart_rx_ctrl_if.master rx_bus
);

    localparam int HALF   = CLKS_PER_BIT / 2;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(DATA_BITS);

    localparam logic [BAUD_W-1:0] HALF_TICK = BAUD_W'(HALF - 1);
    localparam logic [BAUD_W-1:0] LAST_TICK = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_BITS - 1);

    logic                 line;
    rx_state_e            state, state_next;
    logic [BAUD_W-1:0]    baud_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] shift;
    logic                 tick, half_tick;
    logic                 data_sample, stop_sample, deliver, frame_bad;

    logic [DATA_BITS-1:0] rx_data_q;
    logic                 rx_valid_q;
    logic                 frame_err_q;
    logic                 overrun_q;

    uart_rx_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst   (rst),
        .serial(rx_serial),
        .line  (line)
    );

    assign tick        = (baud_cnt == LAST_TICK);
    assign half_tick   = (baud_cnt == HALF_TICK);
    assign data_sample = (state == DATA) && tick;
    assign stop_sample = (state == STOP) && tick;
    assign deliver     = stop_sample && line;
    assign frame_bad   = stop_sample && !line;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (!line) state_next = START;
            START:   if (half_tick) state_next = line ? IDLE : DATA;
            DATA: begin
                if (tick && (bit_cnt == LAST_BIT)) begin
`ifdef UART_RX_PARITY_EN
                    state_next = PARITY;
`else
                    state_next = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY:  if (tick) state_next = STOP;
`endif
            STOP:    if (tick) state_next = line ? IDLE : BREAK;
            BREAK:   if (line) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Sampling stage: baud/bit counters and the LSB-first shift register
    always_ff @(posedge clk) begin
        if (rst) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
        end else begin
            if ((state_next != state) || (state == IDLE) || tick) begin
                baud_cnt <= '0;
            end else begin
                baud_cnt <= baud_cnt + BAUD_W'(1);
            end

            if ((state == START) && (state_next == DATA)) begin
                bit_cnt <= '0;
            end else if (data_sample && (bit_cnt != LAST_BIT)) begin
                bit_cnt <= bit_cnt + BIT_W'(1);
            end

            if (data_sample) begin
                shift[bit_cnt] <= line;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    logic parity_bad;
    logic parity_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            parity_bad   <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            if ((state == PARITY) && tick) begin
                parity_bad <= ((^shift) ^ line) != (PARITY_ODD != 0);
            end
            parity_err_q <= deliver && parity_bad;
        end
    end

    assign rx_bus.parity_err = parity_err_q;
`endif

    // Delivery stage: holding register and one-cycle status pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            frame_err_q <= frame_bad;
            overrun_q   <= 1'b0;
            if (deliver && (!rx_valid_q || rx_bus.rx_ready)) begin
                rx_data_q  <= shift;
                rx_valid_q <= 1'b1;
            end else if (deliver) begin
                overrun_q <= 1'b1;
            end else if (rx_valid_q && rx_bus.rx_ready) begin
                rx_valid_q <= 1'b0;
            end
        end
    end

    assign rx_bus.rx_data   = rx_data_q;
    assign rx_bus.rx_valid  = rx_valid_q;
    assign rx_bus.frame_err = frame_err_q;
    assign rx_bus.overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: frame table plus hand-written corner sequences, byte scoreboard.
module tb_uart_rx_ctrl;

    localparam int CPB = 16;
    localparam int DB  = 8;

    logic clk       = 1'b0;
    logic rst       = 1'b1;
    logic rx_serial = 1'b1;

    uart_rx_ctrl_if #(.DATA_BITS(DB)) bus ();

    uart_rx_ctrl #(
        .CLKS_PER_BIT(CPB),
        .DATA_BITS   (DB),
        .SYNC_STAGES (3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_serial(rx_serial),
        .rx_bus   (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];
    int n_valid_cyc = 0;
    int n_accept    = 0;
    int n_ferr      = 0;
    int n_ovr       = 0;
    int n_perr      = 0;
    int n_perr_lone = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Output monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (bus.rx_valid) n_valid_cyc++;
        if (bus.frame_err) n_ferr++;
        if (bus.overrun) n_ovr++;
`ifdef UART_RX_PARITY_EN
        if (bus.parity_err) n_perr++;
        if (bus.parity_err && !bus.rx_valid) n_perr_lone++;
`endif
        if (bus.rx_valid && bus.rx_ready) begin
            n_accept++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rx_data_unexpected: got %0h, expected no byte", bus.rx_data);
            end else begin
                check("rx_data", 32'(bus.rx_data), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        rx_serial = b;
        repeat (CPB) tick();
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < DB; i++) send_bit(data[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(^data);
`endif
        send_bit(stop);
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic send_frame_par(input logic [7:0] data, input logic par);
        send_bit(1'b0);
        for (int i = 0; i < DB; i++) send_bit(data[i]);
        send_bit(par);
        send_bit(1'b1);
    endtask
`endif

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         idle_bits;
        int         exp_acc;
        int         exp_ferr;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int a0, f0, v0, o0, p0;

        vecs[0] = '{8'hA5, 1'b1, 1, 1, 0};
        vecs[1] = '{8'h00, 1'b1, 0, 1, 0};
        vecs[2] = '{8'hFF, 1'b1, 0, 1, 0};
        vecs[3] = '{8'h5A, 1'b1, 2, 1, 0};
        vecs[4] = '{8'h55, 1'b0, 2, 0, 1};
        vecs[5] = '{8'h0F, 1'b1, 1, 1, 0};
        vecs[6] = '{8'h80, 1'b1, 1, 1, 0};

        bus.rx_ready = 1'b1;
        repeat (3) tick();
        check("reset_rx_valid", 32'(bus.rx_valid), 0);
        check("reset_rx_data", 32'(bus.rx_data), 0);
        check("reset_frame_err", 32'(bus.frame_err), 0);
        check("reset_overrun", 32'(bus.overrun), 0);
        rst = 1'b0;
        repeat (10) tick();

        for (int i = 0; i < 7; i++) begin
            a0 = n_accept; f0 = n_ferr; v0 = n_valid_cyc; o0 = n_ovr;
            if (vecs[i].stop) exp_q.push_back(vecs[i].data);
            send_frame(vecs[i].data, vecs[i].stop);
            check($sformatf("vec%0d_accept", i), 32'(n_accept - a0), 32'(vecs[i].exp_acc));
            check($sformatf("vec%0d_valid_cycles", i), 32'(n_valid_cyc - v0), 32'(vecs[i].exp_acc));
            check($sformatf("vec%0d_frame_err", i), 32'(n_ferr - f0), 32'(vecs[i].exp_ferr));
            check($sformatf("vec%0d_overrun", i), 32'(n_ovr - o0), 0);
            rx_serial = 1'b1;
            repeat (vecs[i].idle_bits * CPB) tick();
        end

        // Backpressure and overrun
        bus.rx_ready = 1'b0;
        a0 = n_accept; o0 = n_ovr;
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1);
        send_frame(8'hC3, 1'b1);
        rx_serial = 1'b1;
        repeat (CPB) tick();
        check("bp_overrun", 32'(n_ovr - o0), 1);
        check("bp_rx_valid", 32'(bus.rx_valid), 1);
        check("bp_rx_data", 32'(bus.rx_data), 32'h3C);
        check("bp_no_accept", 32'(n_accept - a0), 0);
        bus.rx_ready = 1'b1;
        tick();
        check("bp_valid_drop", 32'(bus.rx_valid), 0);
        check("bp_accept", 32'(n_accept - a0), 1);

        // Glitch rejection
        v0 = n_valid_cyc; f0 = n_ferr; o0 = n_ovr;
        rx_serial = 1'b0;
        repeat (5) tick();
        rx_serial = 1'b1;
        repeat (40) tick();
        check("glitch_valid", 32'(n_valid_cyc - v0), 0);
        check("glitch_frame_err", 32'(n_ferr - f0), 0);
        check("glitch_overrun", 32'(n_ovr - o0), 0);

        // Framing error followed by a long break
        v0 = n_valid_cyc; f0 = n_ferr;
        send_frame(8'h55, 1'b0);
        rx_serial = 1'b0;
        repeat (40 * CPB) tick();
        check("break_frame_err", 32'(n_ferr - f0), 1);
        check("break_no_valid", 32'(n_valid_cyc - v0), 0);
        rx_serial = 1'b1;
        repeat (2 * CPB) tick();
        a0 = n_accept;
        exp_q.push_back(8'h0F);
        send_frame(8'h0F, 1'b1);
        check("after_break_accept", 32'(n_accept - a0), 1);

        // Reset during data bit 4, with a byte still held
        bus.rx_ready = 1'b0;
        send_frame(8'h12, 1'b1);
        check("pre_reset_held", 32'(bus.rx_valid), 1);
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        rx_serial = 1'b1;
        repeat (CPB / 2) tick();
        rst = 1'b1;
        tick();
        check("midrst_rx_valid", 32'(bus.rx_valid), 0);
        check("midrst_rx_data", 32'(bus.rx_data), 0);
        check("midrst_frame_err", 32'(bus.frame_err), 0);
        check("midrst_overrun", 32'(bus.overrun), 0);
        rst = 1'b0;
        bus.rx_ready = 1'b1;
        repeat (2 * CPB) tick();
        a0 = n_accept;
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1);
        check("after_rst_accept", 32'(n_accept - a0), 1);

`ifdef UART_RX_PARITY_EN
        p0 = n_perr;
        exp_q.push_back(8'h07);
        send_frame_par(8'h07, 1'b1);
        check("parity_good", 32'(n_perr - p0), 0);
        rx_serial = 1'b1;
        repeat (CPB) tick();
        exp_q.push_back(8'h07);
        send_frame_par(8'h07, 1'b0);
        check("parity_bad", 32'(n_perr - p0), 1);
        check("parity_with_valid", 32'(n_perr_lone), 0);
`else
        p0 = n_perr;
        check("no_parity_err", 32'(p0), 0);
`endif

        rx_serial = 1'b1;
        repeat (20) tick();
        check("scoreboard_empty", 32'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
